alu_share_arbiter: RTL

Round-robin arbiter that time-shares the single combinational 32-bit ALU among NUM_REQ requesters. Each requester uses a valid/ready handshake. The arbiter steers the granted operands and opcode to the ALU, then captures the result and status flags in a one-entry response register with backpressure. It sits between the issue-side requesters (execute slots, address-gen, branch compare) and the ALU instance.

---
 rtl/alu_share_arbiter_if.sv | 34 +++
 rtl/alu_share_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// Requester and response bundle for the shared-ALU arbiter.
// master = issue/consumer side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_zero;
  logic                     rsp_sign;
  logic                     rsp_overflow;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result,
    input  rsp_zero, rsp_sign, rsp_overflow
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result,
    output rsp_zero, rsp_sign, rsp_overflow
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin time-sharing of one combinational ALU among NUM_REQ
// requesters, with a one-entry response register and backpressure.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus,
  output logic [1:0]         alu_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zero,
  input  logic               alu_sign,
  input  logic               alu_overflow,
  output logic [15:0]        op_count
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]  r_ptr;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_sign;
  logic             r_rsp_ovf;
  logic [15:0]      r_op_count;

  logic             w_gnt_vld;
  logic [ID_W-1:0]  w_gnt_id;
  logic             w_can_acc;
  logic             w_xfer;
  logic [ID_W-1:0]  w_ptr_nxt;

  function automatic logic [ID_W-1:0] wrap_idx(
    input logic [ID_W-1:0] base,
    input int              k
  );
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Scan from the farthest slot down so the nearest-to-ptr hit wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap_idx(r_ptr, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = wrap_idx(r_ptr, k);
      end
    end
  end

  assign w_can_acc = !r_rsp_valid || bus.rsp_ready;
  assign w_xfer    = rst_n && w_gnt_vld && w_can_acc;
  assign w_ptr_nxt = wrap_idx(w_gnt_id, 1);

  always_comb begin
    bus.req_ready = '0;
    if (w_xfer) bus.req_ready[w_gnt_id] = 1'b1;
  end

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (w_gnt_vld) begin
      alu_op = bus.req_op[2*int'(w_gnt_id) +: 2];
      alu_a  = bus.req_a[WIDTH*int'(w_gnt_id) +: WIDTH];
      alu_b  = bus.req_b[WIDTH*int'(w_gnt_id) +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_sign   <= 1'b0;
      r_rsp_ovf    <= 1'b0;
      r_op_count   <= '0;
    end else if (w_xfer) begin
      r_ptr        <= w_ptr_nxt;
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_gnt_id;
      r_rsp_result <= alu_result;
      r_rsp_zero   <= alu_zero;
      r_rsp_sign   <= alu_sign;
      r_rsp_ovf    <= alu_overflow;
      if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
    end else if (bus.rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_id       = r_rsp_id;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_zero     = r_rsp_zero;
  assign bus.rsp_sign     = r_rsp_sign;
  assign bus.rsp_overflow = r_rsp_ovf;
  assign op_count         = r_op_count;
endmodule
